fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 97 +++++++++
 tb/tb_fetch_buffer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_pkg
// Description : Shared CPU definitions: bubble instruction and buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_buffer_pkg;

    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : FIFO between fetch and decode; emits NOP_INST bubbles when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_misalign,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    fetch_entry_t        r_mem_q [DEPTH];
    fetch_entry_t        w_entry_d;
    fetch_entry_t        w_head_entry;
    logic [c_PTR_W-1:0]  r_head_q, w_head_d;
    logic [c_PTR_W-1:0]  r_tail_q, w_tail_d;
    logic [c_CNT_W-1:0]  r_count_q, w_count_d;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;

    assign w_empty      = (r_count_q == '0);
    assign in_ready     = (r_count_q < c_FULL);
    assign w_push       = in_valid && in_ready && !flush;
    assign w_pop        = !w_empty && out_ready && !flush;
    assign w_head_entry = r_mem_q[r_head_q];

    always_comb begin
        w_entry_d          = '0;
        w_entry_d.pc       = in_pc;
        w_entry_d.inst     = in_inst;
        w_entry_d.misalign = (in_pc[1:0] != 2'b00);

        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end else begin
            // Pointers are log2(DEPTH) bits, so the increment wraps on its own.
            if (w_push) w_tail_d = r_tail_q + 1'b1;
            if (w_pop)  w_head_d = r_head_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Entry data is never reset; every output is masked by the occupancy.
    always_ff @(posedge clk) begin
        if (rstn && w_push) r_mem_q[r_tail_q] <= w_entry_d;
    end

    assign count        = r_count_q;
    assign out_valid    = !w_empty;
    assign out_pc       = w_empty ? 32'h0 : w_head_entry.pc;
    assign out_inst     = w_empty ? NOP_INST : w_head_entry.inst;
    assign out_misalign = w_empty ? 1'b0 : w_head_entry.misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Vector table plus scoreboarded streaming run for fetch_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int          c_DEPTH = 2;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic        out_ready;
    logic        flush;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_buffer #(.DEPTH(c_DEPTH), .NOP_INST(c_NOP)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_misalign(out_misalign), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_mis;
        logic [1:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic vec_t mk(input logic rn, input logic iv, input logic [31:0] pc,
                                input logic [31:0] inst, input logic ordy, input logic fl,
                                input logic e_ov, input logic [31:0] e_pc,
                                input logic [31:0] e_inst, input logic e_mis,
                                input logic [1:0] e_cnt, input logic e_ir);
        vec_t v;
        v.rn = rn; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_mis = e_mis;
        v.e_cnt = e_cnt; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        int          mcount;
        logic        push;
        logic        pop;
        logic [31:0] spc;
        sb_t         e;
        sb_t         ne;

        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; flush = 1'b0;

        //        rn iv pc      inst          ordy fl  ov  pc      inst          mis cnt ir
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 0,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h0,   32'h00500093, 0, 0,  1, 32'h0,   32'h00500093, 0, 1, 1));
        vecs.push_back(mk(1, 1, 32'h4,   32'h00100113, 0, 0,  1, 32'h0,   32'h00500093, 0, 2, 0));
        vecs.push_back(mk(1, 1, 32'h8,   32'h00A00113, 0, 0,  1, 32'h0,   32'h00500093, 0, 2, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0,  1, 32'h4,   32'h00100113, 0, 1, 1));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h10,  32'h11,       0, 0,  1, 32'h10,  32'h11,       0, 1, 1));
        vecs.push_back(mk(1, 1, 32'h14,  32'h22,       0, 0,  1, 32'h10,  32'h11,       0, 2, 0));
        vecs.push_back(mk(1, 1, 32'h18,  32'h33,       1, 1,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h102, 32'h44,       0, 0,  1, 32'h102, 32'h44,       1, 1, 1));
        vecs.push_back(mk(1, 1, 32'h104, 32'h55,       0, 0,  1, 32'h102, 32'h44,       1, 2, 0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0,  1, 32'h104, 32'h55,       0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h200, 32'h66,       0, 0,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h300, 32'h77,       0, 0,  1, 32'h300, 32'h77,       0, 1, 1));
        vecs.push_back(mk(1, 1, 32'h304, 32'h88,       0, 0,  1, 32'h300, 32'h77,       0, 2, 0));
        vecs.push_back(mk(1, 1, 32'h308, 32'h99,       1, 0,  1, 32'h304, 32'h88,       0, 1, 1));
        vecs.push_back(mk(1, 1, 32'h30C, 32'hAA,       1, 0,  1, 32'h30C, 32'hAA,       0, 1, 1));
        vecs.push_back(mk(1, 1, 32'h400, 32'hBB,       0, 1,  0, 32'h0,   c_NOP,        0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h401, 32'hCC,       0, 0,  1, 32'h401, 32'hCC,       1, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rstn = vecs[i].rn; in_valid = vecs[i].iv; in_pc = vecs[i].pc;
            in_inst = vecs[i].inst; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clk);
            #1;
            check("out_valid",    i, 32'(out_valid),    32'(vecs[i].e_ov));
            check("out_pc",       i, out_pc,            vecs[i].e_pc);
            check("out_inst",     i, out_inst,          vecs[i].e_inst);
            check("out_misalign", i, 32'(out_misalign), 32'(vecs[i].e_mis));
            check("count",        i, 32'(count),        32'(vecs[i].e_cnt));
            check("in_ready",     i, 32'(in_ready),     32'(vecs[i].e_ir));
        end

        // Streaming run: 10 back-to-back pushes with the consumer always ready.
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        mcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b1;
            if (c < 10) begin
                spc = 32'(c) * 32'd4;
                in_valid = 1'b1; in_pc = spc; in_inst = 32'h0010_0000 | spc;
            end else begin
                in_valid = 1'b0; in_pc = '0; in_inst = '0;
            end
            check("stream_count", 100 + c, 32'(count),     32'(mcount));
            check("stream_valid", 100 + c, 32'(out_valid), 32'(mcount > 0));
            push = in_valid && (mcount < c_DEPTH);
            pop  = (mcount > 0) && out_ready;
            if (pop) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_underflow step %0d: got pop expected none", 100 + c);
                end else begin
                    e = sb.pop_front();
                    check("stream_pc",   100 + c, out_pc,   e.pc);
                    check("stream_inst", 100 + c, out_inst, e.inst);
                end
            end
            if (push) begin
                ne.pc = in_pc; ne.inst = in_inst;
                sb.push_back(ne);
            end
            mcount = mcount + int'(push) - int'(pop);
            @(posedge clk);
            if (c >= 10 && sb.size() == 0 && mcount == 0) break;
        end
        check("stream_drained", 200, 32'(sb.size()), 32'd0);

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
